// File: rtl/pdu_dmem_ctrl_if.sv
// Request/response bus between the PDU command/debug logic and the DMEM controller.
// master = requester, slave = pdu_dmem_ctrl.
interface pdu_dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/pdu_dmem_ctrl.sv
// Byte-addressed, byte-strobed single-beat front-end for the PDU data memory.
// Partial-strobe writes are done as read-modify-write because DMEM only takes full words.
module pdu_dmem_ctrl #(
    parameter int unsigned DEPTH = 12
) (
    input  logic               sys_clk,
    input  logic               sys_rstn,
    pdu_dmem_ctrl_if.slave     bus,
    output logic [DEPTH-1:0]   dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               dmem_we,
    input  logic [31:0]        dmem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdWait,
        StRmwIssue,
        StRmwMerge,
        StWr,
        StResp
    } state_t;

    state_t      state;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] merged;
    logic        addr_misaligned;
    logic        addr_oob;

    assign addr_misaligned = (bus.req_addr[1:0] != 2'b00);
    // Any bit above the word-index field means the address is past the end of DMEM.
    assign addr_oob        = ((bus.req_addr >> (DEPTH + 2)) != 32'd0);

    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : dmem_rdata[8*i +: 8];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state          <= StIdle;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_we        <= 1'b0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
        end else begin
            case (state)
                StIdle: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if (addr_misaligned || addr_oob) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                            state          <= StResp;
                        end else begin
                            dmem_addr <= bus.req_addr[DEPTH+1:2];
                            // A write with no strobes is served as a read.
                            if (!bus.req_we || (bus.req_wstrb == 4'h0)) begin
                                state <= StRdIssue;
                            end else if (bus.req_wstrb == 4'hF) begin
                                dmem_wdata <= bus.req_wdata;
                                dmem_we    <= 1'b1;
                                state      <= StWr;
                            end else begin
                                wdata_q <= bus.req_wdata;
                                wstrb_q <= bus.req_wstrb;
                                state   <= StRmwIssue;
                            end
                        end
                    end
                end
                StRdIssue: state <= StRdWait;
                StRdWait: begin
                    bus.resp_rdata <= dmem_rdata;
                    bus.resp_valid <= 1'b1;
                    state          <= StResp;
                end
                StRmwIssue: state <= StRmwMerge;
                StRmwMerge: begin
                    dmem_wdata <= merged;
                    dmem_we    <= 1'b1;
                    state      <= StWr;
                end
                StWr: begin
                    dmem_we        <= 1'b0;
                    bus.resp_rdata <= dmem_wdata;
                    bus.resp_valid <= 1'b1;
                    state          <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pdu_dmem_ctrl.sv
// Directed bench for pdu_dmem_ctrl with a synchronous-read DMEM model.
module tb_pdu_dmem_ctrl;
    localparam int unsigned DEPTH = 12;

    logic             sys_clk;
    logic             sys_rstn;
    logic [DEPTH-1:0] dmem_addr;
    logic [31:0]      dmem_wdata;
    logic             dmem_we;
    logic [31:0]      dmem_rdata;

    logic             pre_we;
    logic [DEPTH-1:0] pre_addr;
    logic [31:0]      pre_data;
    logic [31:0]      mem [0:(1<<DEPTH)-1];
    int               we_cnt;

    int total;
    int bad;

    pdu_dmem_ctrl_if bus ();

    pdu_dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .sys_clk    (sys_clk),
        .sys_rstn   (sys_rstn),
        .bus        (bus.slave),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Read data appears one edge after the address is sampled; reads return the old word.
    always @(posedge sys_clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (dmem_we) mem[dmem_addr] <= dmem_wdata;
        dmem_rdata <= mem[dmem_addr];
    end

    initial we_cnt = 0;
    always @(posedge sys_clk) if (dmem_we === 1'b1) we_cnt <= we_cnt + 1;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0BAD_0BAD;
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk("hs_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
    endtask

    int we0;

    initial begin
        total = 0;
        bad   = 0;
        sys_rstn       = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.resp_ready = 1'b0;
        pre_we   = 1'b1;
        pre_addr = 12'd4;
        pre_data = 32'hDEAD_BEEF;
        step();
        pre_addr = 12'd8;
        pre_data = 32'h0;
        step();
        pre_we = 1'b0;
        step();

        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_dmem_addr", {20'd0, dmem_addr}, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);

        sys_rstn = 1'b1;
        chk("rel_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
        step();
        chk("rel_req_ready_high", {31'd0, bus.req_ready}, 32'd1);

        // Read word 4
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        chk("rd_dmem_addr", {20'd0, dmem_addr}, 32'd4);
        chk("rd_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rd_valid_e0", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("rd_valid_e1", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("rd_valid_e2", {31'd0, bus.resp_valid}, 32'd1);
        chk("rd_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
        chk("rd_err", {31'd0, bus.resp_err}, 32'd0);
        handshake();

        // Full write to word 8
        we0 = we_cnt;
        issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
        chk("fw_we_e0", {31'd0, dmem_we}, 32'd1);
        chk("fw_addr", {20'd0, dmem_addr}, 32'd8);
        chk("fw_wdata", dmem_wdata, 32'h1234_5678);
        step();
        chk("fw_we_e1", {31'd0, dmem_we}, 32'd0);
        chk("fw_valid_e1", {31'd0, bus.resp_valid}, 32'd1);
        chk("fw_rdata", bus.resp_rdata, 32'h1234_5678);
        chk("fw_we_pulses", we_cnt - we0, 32'd1);
        chk("fw_mem8", mem[8], 32'h1234_5678);
        handshake();

        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        step();
        step();
        chk("rdback_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("rdback_rdata", bus.resp_rdata, 32'h1234_5678);
        handshake();

        // Partial write, strobe 0101
        we0 = we_cnt;
        issue(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        chk("pw_we_e0", {31'd0, dmem_we}, 32'd0);
        step();
        chk("pw_we_e1", {31'd0, dmem_we}, 32'd0);
        step();
        chk("pw_we_e2", {31'd0, dmem_we}, 32'd1);
        chk("pw_wdata", dmem_wdata, 32'h12BB_56DD);
        chk("pw_valid_e2", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("pw_we_e3", {31'd0, dmem_we}, 32'd0);
        chk("pw_valid_e3", {31'd0, bus.resp_valid}, 32'd1);
        chk("pw_rdata", bus.resp_rdata, 32'h12BB_56DD);
        chk("pw_we_pulses", we_cnt - we0, 32'd1);
        chk("pw_mem8", mem[8], 32'h12BB_56DD);
        handshake();

        // Misaligned write is rejected
        we0 = we_cnt;
        issue(1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'hF);
        chk("mis_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("mis_err", {31'd0, bus.resp_err}, 32'd1);
        chk("mis_rdata", bus.resp_rdata, 32'd0);
        chk("mis_we", {31'd0, dmem_we}, 32'd0);
        handshake();
        chk("mis_err_clr", {31'd0, bus.resp_err}, 32'd0);
        chk("mis_we_pulses", we_cnt - we0, 32'd0);

        // Out-of-range write is rejected
        issue(1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
        chk("oob_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("oob_err", {31'd0, bus.resp_err}, 32'd1);
        chk("oob_rdata", bus.resp_rdata, 32'd0);
        handshake();
        chk("oob_we_pulses", we_cnt - we0, 32'd0);

        // Zero-strobe write acts as a read
        issue(1'b1, 32'h0000_0020, 32'h5555_5555, 4'h0);
        step();
        chk("zs_valid_e1", {31'd0, bus.resp_valid}, 32'd0);
        step();
        chk("zs_valid_e2", {31'd0, bus.resp_valid}, 32'd1);
        chk("zs_rdata", bus.resp_rdata, 32'h12BB_56DD);
        handshake();
        chk("zs_we_pulses", we_cnt - we0, 32'd0);
        chk("zs_mem8", mem[8], 32'h12BB_56DD);

        // Backpressure with a competing request held high
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        step();
        step();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0020;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
            chk("bp_err", {31'd0, bus.resp_err}, 32'd0);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_addr", {20'd0, dmem_addr}, 32'd4);
        end
        bus.req_valid = 1'b0;
        handshake();
        chk("bp_we_pulses", we_cnt - we0, 32'd0);
        chk("bp_mem8", mem[8], 32'h12BB_56DD);

        // Reset during RMW_MERGE
        issue(1'b1, 32'h0000_0020, 32'h0000_0000, 4'b0001);
        step();
        sys_rstn = 1'b0;
        #1;
        chk("mr_we", {31'd0, dmem_we}, 32'd0);
        chk("mr_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("mr_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("mr_resp_rdata", bus.resp_rdata, 32'd0);
        chk("mr_dmem_addr", {20'd0, dmem_addr}, 32'd0);
        chk("mr_dmem_wdata", dmem_wdata, 32'd0);
        step();
        step();
        sys_rstn = 1'b1;
        chk("mr_rel_low", {31'd0, bus.req_ready}, 32'd0);
        step();
        chk("mr_rel_high", {31'd0, bus.req_ready}, 32'd1);
        chk("mr_mem8", mem[8], 32'h12BB_56DD);
        chk("mr_we_pulses", we_cnt - we0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdu_dmem_ctrl.md
Name: pdu_dmem_ctrl

Overview:
- Request/response front-end that sits directly upstream of the PDU data memory. It drives the memory's word address, write data and write enable.
- Converts byte-addressed, byte-strobed single-beat requests from the PDU command/debug logic into word accesses on the DMEM port.
- The DMEM port supports full-word writes only, so partial-strobe writes are done as read-modify-write.
- One outstanding request at a time; valid/ready handshake on both request and response.

Parameters:
DEPTH, 12, log2 of DMEM word count; must match the DMEM instance.

Ports:
sys_clk  in  1  system clock, rising edge
sys_rstn  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data, little-endian byte lanes
req_wstrb  in  4  byte write strobes; ignored for reads
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  read data, or final word written for writes
resp_err  out  1  request rejected, no DMEM access made
dmem_addr  out  DEPTH  word address to DMEM
dmem_wdata  out  32  write data to DMEM
dmem_we  out  1  DEMEM write enable, one cycle per write
dmem_rdata  in  32  DMEM read data; valid one edge after dmem_addr is sampled

Behaviour:
- Reset (async, sys_rstn=0):
  - state=IDLE; req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, dmem_addr=0, dmem_wdata=0, dmem_we=0.
  - req_ready registered; it rises on the first sys_clk edge after reset release.
- All outputs are registered; no combinational path from request inputs to outputs.
- Acceptance:
  - Edge E0 with req_valid & req_ready. req_ready drops at E0 and stays low until the controller returns to IDLE.
- Checks at E0, in priority order:
  - req_addr[1:0]!=0 → error.
  - req_addr[31:DEPTH+2]!=0 → error.
  - Word index = req_addr[DEPTH+1:2].
- States: IDLE, RD_ISSUE, RD_WAIT, RMW_ISSUE, RMW_MERGE, WR, RESP.
- Error path:
  - E0 → RESP with resp_err=1, resp_rdata=0.
  - resp_valid visible after E0; dmem_we never asserted.
- Read:
  - E0: dmem_addr←index, go to RD_ISSUE.
  - E1: go to RD_WAIT.
  - E2: resp_rdata←dmem_rdata, resp_valid←1, go to RESP.
  - Latency: resp_valid high after edge E0+2.
- Full write (wstrb=4'hF):
  - E0: dmem_addr, dmem_wdata←req_wdata, dmem_we←1, go to WR.
  - E1: dmem_we←0, resp_rdata←written word, resp_valid←1, go to RESP.
- Partial write (wstrb not 0 and not F):
  - E0: dmem_addr set, latch wdata/wstrb, go to RMW_ISSUE.
  - E1: go to RMW_MERGE.
  - E2: merged byte i = wstrb[i] ? wdata byte i : dmem_rdata byte i; dmem_wdata←merged, dmem_we←1, go to WR.
  - E3: response as for full write; resp_rdata = merged word.
- Zero-strobe write:
  - Treated as a read (RD path).
  - Response returns the current word; no dmem_we.
- dmem_we is high for exactly one cycle per write and never during reads or errors.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready.
  - On the handshake edge: resp_valid←0, resp_err←0, req_ready←1, go to IDLE.
  - resp_ready asserted before resp_valid has no effect.
- Request inputs are sampled only at E0; changes while busy are ignored.
- Reset mid-operation:
  - Immediate return to reset values, including dmem_we=0.
  - A write whose dmem_we edge has not yet occurred is not committed.
  - A pending response is discarded.
- Address wrap: none; out-of-range addresses produce an error.

Test Plan:
- After reset, read addr 0x0000_0010 with DMEM word 4 = 0xDEADBEEF → dmem_addr=4, resp_valid at E0+2, resp_rdata=0xDEADBEEF, resp_err=0.
- Full write 0x12345678 to 0x20, strobe F → one dmem_we pulse at addr 8; resp at E0+1 with rdata=0x12345678. A following read of 0x20 returns 0x12345678.
- Word 8 = 0x12345678; write 0xAABBCCDD to 0x20 with strobe 4'b0101 → dmem_wdata=0x12BB56DD, response at E0+3, rdata=0x12BB56DD.
- Error cases: addr 0x22 → resp_err=1, rdata=0, no dmem_we. Addr 0x0000_4000 (DEPTH=12) → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid, resp_rdata and resp_err stable, req_ready=0, a new req_valid is not accepted; release → IDLE and req_ready=1 next cycle.
- Assert sys_rstn=0 during RMW_MERGE → dmem_we stays 0, memory word unchanged, all outputs at reset values; req_ready=1 one edge after release.
